// File: rtl/issue_gather_if.sv
// Beat-in / group-out bus for issue_gather: upstream lane beats, downstream
// 8-lane group handshake and the sticky error flag.
interface issue_gather_if #(
  parameter int DW = 8
);
  logic          stall_n;
  logic          i_act;
  logic [1:8]    i_lv;
  logic [DW-1:0] i_d [1:8];
  logic          i_et;
  logic          o_vl;
  logic [DW-1:0] o_d [1:8];
  logic [7:0]    o_mask;
  logic          i_rdy;
  logic          o_err;

  modport master (
    input  stall_n, o_vl, o_d, o_mask, o_err,
    output i_act, i_lv, i_d, i_et, i_rdy
  );

  modport slave (
    output stall_n, o_vl, o_d, o_mask, o_err,
    input  i_act, i_lv, i_d, i_et, i_rdy
  );
endinterface

// File: rtl/issue_gather.sv
// Reassembles serialized lane beats into 8-lane groups behind a 2-entry FIFO.
// Optional ISSUE_GATHER_DUP_CHECK_EN enables the sticky duplicate-lane error.
module issue_gather #(
  parameter int DW = 8
) (
  input logic         clk,
  input logic         rst,
  issue_gather_if.slave bus
);

  logic [DW-1:0] acc_d_q [1:8];
  logic [DW-1:0] acc_d_d [1:8];
  logic [7:0]    acc_m_q, acc_m_d;

  logic [DW-1:0] fifo_d_q [2][1:8];
  logic [DW-1:0] fifo_d_d [2][1:8];
  logic [7:0]    fifo_m_q [2];
  logic [7:0]    fifo_m_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  logic [DW-1:0] mrg_d [1:8];
  logic [7:0]    mrg_m;
  logic [7:0]    lv_m;
  logic          accept, push, pop;

  assign bus.stall_n = (cnt_q != 2'd2);
  assign bus.o_vl    = (cnt_q != 2'd0);
  assign bus.o_mask  = fifo_m_q[rd_ptr_q];
  assign bus.o_d     = fifo_d_q[rd_ptr_q];

  assign accept = bus.i_act && bus.stall_n;
  assign push   = accept && bus.i_et;
  assign pop    = bus.o_vl && bus.i_rdy;

  // Beat lanes override the accumulator so a closing beat can supply any lane.
  always_comb begin
    lv_m = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      lv_m[k-1] = bus.i_lv[k];
      mrg_d[k]  = bus.i_lv[k] ? bus.i_d[k] : acc_d_q[k];
    end
    mrg_m = acc_m_q | lv_m;
  end

  always_comb begin
    acc_d_d  = acc_d_q;
    acc_m_d  = acc_m_q;
    fifo_d_d = fifo_d_q;
    fifo_m_d = fifo_m_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);

    if (accept) begin
      if (bus.i_et) begin
        for (int unsigned k = 1; k <= 8; k++) acc_d_d[k] = '0;
        acc_m_d = '0;
      end else begin
        acc_d_d = mrg_d;
        acc_m_d = mrg_m;
      end
    end

    if (push) begin
      fifo_d_d[wr_ptr_q] = mrg_d;
      fifo_m_d[wr_ptr_q] = mrg_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= 8; k++) begin
        acc_d_q[k]     <= '0;
        fifo_d_q[0][k] <= '0;
        fifo_d_q[1][k] <= '0;
      end
      acc_m_q     <= '0;
      fifo_m_q[0] <= '0;
      fifo_m_q[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_d_q  <= acc_d_d;
      acc_m_q  <= acc_m_d;
      fifo_d_q <= fifo_d_d;
      fifo_m_q <= fifo_m_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ISSUE_GATHER_DUP_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (accept && (|(lv_m & acc_m_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule

// File: doc/issue_gather.md
# issue_gather

Receive-side counterpart of the lane issue stage. It consumes the serialized per-lane beat stream: up to 8 lanes valid per cycle, with an end-of-group marker on the last beat. It reassembles each group into one 8-lane vector and hands it downstream through a 2-entry output FIFO with valid/ready flow control. It sits between the per-lane serial datapath and the downstream 8-pixel consumer, and applies backpressure upstream through `stall_n`.

## Interface
Parameters:
- `DW`, default 8: data width per lane.

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall_n`  out  1  upstream may present a beat; beats are ignored when 0
- `i_act`  in  1  beat present this cycle
- `i_lv [1:8]`  in  1 each  lane valid in this beat
- `i_d [1:8]`  in  DW each  lane data
- `i_et`  in  1  last beat of group; only meaningful with `i_act`
- `o_vl`  out  1  group available at FIFO head
- `o_d [1:8]`  out  DW each  group lane data; unwritten lanes are 0
- `o_mask`  out  8  bit k-1 set when lane k was written in the group
- `i_rdy`  in  1  downstream accepts the head group
- `o_err`  out  1  sticky duplicate-lane error (see Configuration)

## Operation
- Beat accepted: `i_act && stall_n`.
- Accumulator state:
  - `acc_d[1:8]`: lane data.
  - `acc_m[8]`: lane-written mask.
- For each lane k with `i_lv[k]` in an accepted beat: `acc_d[k] <= i_d[k]`, `acc_m[k] <= 1`.
- Accepted beat with `i_et` (close):
  - Push (`acc` merged with this beat's lanes) into the FIFO.
  - Clear `acc_d` to 0 and `acc_m` to 0 on the same edge.
  - Beat lanes take priority over `acc` in the merge.
- A close beat with no lane valid and `acc_m==0` still pushes an empty group (`o_mask=0`, all `o_d=0`).
- FIFO:
  - 2 entries, pointer wrap mod 2, count 0..2.
  - Pop when `o_vl && i_rdy`.
  - Push and pop in the same cycle leave the count unchanged.
- `stall_n = (fifo_cnt != 2)`, combinational from registered count. It blocks all beats, including non-closing ones.
- `o_vl = (fifo_cnt != 0)`; `o_d` and `o_mask` come from the head entry. Head values are don't-care when `o_vl=0`, but the bench checks only under `o_vl`.
- Lanes may arrive in any beat order. A lane written twice in one group keeps the later value.
- Reset mid-group or mid-FIFO discards everything: accumulator, FIFO contents, count and `o_err`.

## Timing
- Reset values:
  - `stall_n=1`, `o_vl=0`, `o_mask=0`, `o_d` all 0, `o_err=0`.
  - FIFO count 0; accumulator cleared.
- Latency: close beat at edge N; `o_vl=1` with that group is visible after edge N (one cycle).
- Throughput: one group per cycle (one-beat groups) while `i_rdy=1`.
- When `fifo_cnt==2` and a pop occurs at edge N, `stall_n` rises after N; the beat presented in the cycle before N is ignored. Upstream must hold the beat until `stall_n=1`.
- `o_vl`/`o_d` are stable while `o_vl && !i_rdy`.

## Configuration
- `ISSUE_GATHER_DUP_CHECK_EN` defined:
  - `o_err` sets when an accepted beat has `i_lv[k]` with `acc_m[k]` already 1.
  - Cleared only by `rst`.
- Not defined: `o_err` is tied 0; no duplicate-detection logic.

## Test plan
- Single beat, all 8 lanes, `i_d[k]=k`, `i_et=1`, `i_rdy=1` -> next cycle `o_vl=1`, `o_mask=8'hFF`, `o_d[k]=k`; following cycle `o_vl=0`.
- Three beats: lanes {1,2}, {5}, {8}+et, data 8'hA1, 8'hA2, 8'hA5, 8'hA8 -> one group, `o_mask=8'h93`, `o_d[3]=0`, lane data matches.
- `i_rdy=0`, three back-to-back single-beat closes -> third beat sees `stall_n=0` and is ignored. `o_vl` holds group 1. After `i_rdy=1`, groups 1 and 2 appear in order; re-presented group 3 is accepted afterwards.
- Close beat with no lanes valid -> `o_vl=1`, `o_mask=0`, all `o_d=0`.
- `rst` asserted after two non-closing beats and with one group queued -> `o_vl=0` next cycle. A subsequent single-lane-3 close gives `o_mask=8'h04` (no stale lanes).
- With `ISSUE_GATHER_DUP_CHECK_EN`, lane 4 written 8'h11 then 8'h22 in one group -> `o_d[4]=8'h22`, `o_err=1` held until `rst`. Without the macro, `o_err` stays 0.
